// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS fields into R/I/J words, tags each with a
// sequential word address and queues them in a small FIFO drained by valid/ready.
module instr_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              bad_fmt,
    output logic [7:0]        err_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       r_mem_word [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_bad_fmt;
    logic [7:0]        r_err_count;

    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_tag;

    // Handshake decode; ready and valid depend only on the registered occupancy.
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid && in_ready;
    assign w_legal   = (fmt != 2'd3);
    assign w_push    = w_accept && w_legal;
    assign w_pop     = out_valid && out_ready;
    // A base load in the same cycle as a push tags the pushed word with base_addr.
    assign w_tag     = base_load ? base_addr : r_addr;

    assign out_word  = r_mem_word[r_rd_ptr];
    assign out_addr  = r_mem_addr[r_rd_ptr];
    assign bad_fmt   = r_bad_fmt;
    assign err_count = r_err_count;

    // Field packing for the selected instruction format.
    always_comb begin
        w_word = '0;
        case (fmt)
            2'd0:    w_word = {op, rs, rt, rd, shamt, funct};
            2'd1:    w_word = {op, rs, rt, imm};
            2'd2:    w_word = {op, jaddr};
            default: w_word = '0;
        endcase
    end

    // FIFO storage: write the packed word and its tag at the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_word[i] <= '0;
                r_mem_addr[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_word[r_wr_ptr] <= w_word;
            r_mem_addr[r_wr_ptr] <= w_tag;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Word-address counter: base load, then post-increment on each legal push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_push) begin
            r_addr <= w_tag + ADDR_W'(1);
        end else if (base_load) begin
            r_addr <= base_addr;
        end
    end

    // Illegal-format pulse and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bad_fmt   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_bad_fmt <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Buffered MIPS instruction encoder: accepts decoded instruction fields (op, rs, rt, rd, shamt, funct, imm, jaddr) with a format select and packs them into 32-bit R/I/J instruction words. The words are queued in a small FIFO, each tagged with a sequential word address, and drained over a valid/ready interface. It sits between the test/program loader and instruction memory, and is the write-side counterpart of the instruction decoder.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_W, 10: width of the word-address counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  field bundle present.
- in_ready  out  1  encoder can accept a bundle this cycle.
- fmt  in  2  0 = R, 1 = I, 2 = J, 3 = illegal.
- op  in  6  opcode.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- funct  in  6  function code.
- imm  in  16  immediate.
- jaddr  in  26  jump target field.
- base_load  in  1  load the address counter from base_addr.
- base_addr  in  ADDR_W  new address-counter value.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address tagged on the head entry.
- bad_fmt  out  1  one-cycle pulse after an illegal bundle is accepted.
- err_count  out  8  saturating count of illegal bundles.

## Operation
- Packing rules:
  - R: {op, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm}.
  - J: {op, jaddr}.
  - Unused inputs are ignored.
- Accept: in_valid && in_ready.
- Legal fmt: the packed word and the current address counter are pushed, then the counter increments (mod 2^ADDR_W).
- Illegal fmt (3):
  - The bundle is accepted and dropped; nothing is enqueued.
  - The counter is unchanged.
  - bad_fmt pulses and err_count increments, saturating at 255.
- base_load:
  - Counter ← base_addr.
  - If an accept occurs in the same cycle, the enqueued word takes base_addr and the counter becomes base_addr+1.
  - Entries already queued keep their tags.
- Pop: out_valid && out_ready; the FIFO head advances.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count (0..DEPTH).
  - out_word and out_addr are driven from the head entry.
  - When out_valid=0 their value is don't-care, but stable.
- in_ready = (count != DEPTH). It is registered-state-only, with no combinational path from out_ready.
- out_valid = (count != 0).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_word=0, out_addr=0.
  - bad_fmt=0, err_count=0, address counter=0, pointers and count=0.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously); queued words are lost.
- Latency: a bundle accepted at edge N appears with out_valid=1 after edge N (usable in cycle N+1).
- Throughput: one bundle per cycle while not full; with out_ready held high, a continuous stream never stalls.
- Full, with a push attempt: in_ready=0, so the bundle is not accepted. This holds even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Empty: no pop occurs even if out_ready=1. A push to an empty FIFO becomes visible the next cycle (no bypass).
- Pointers wrap modulo DEPTH. The address counter wraps from 2^ADDR_W−1 to 0.
- bad_fmt: high exactly one cycle, in the cycle after the illegal accept. It pulses again for back-to-back illegal accepts.

## Test plan
- **Reset and encoding.**
  - Stimulus: reset; push I op=35 rs=19 rt=8 imm=32; push R op=0 rs=17 rt=18 rd=16 shamt=0 funct=32; push J op=2 jaddr=257; out_ready=1.
  - Required response: out_word 0x8E680020 @0, 0x02328020 @1, 0x08000101 @2; each out_valid is 1 cycle after its accept.
- **Full and backpressure.**
  - Stimulus: out_ready=0, push DEPTH+2 legal bundles.
  - Required response: in_ready falls after 4 accepts; the 5th is held. Raising out_ready for one cycle pops @0, then in_ready rises next cycle and the held bundle is tagged @4.
- **Illegal format.**
  - Stimulus: push fmt=3, then a legal J jaddr=5.
  - Required response: no output for the fmt=3 bundle; bad_fmt pulses one cycle; err_count=1. The J word 0x08000005 is tagged @0.
- **base_load.**
  - Stimulus: base_load with base_addr=0x3FF concurrent with a push, then two more pushes.
  - Required response: tags are 0x3FF, 0x000, 0x001.
- **Simultaneous push and pop at count=2.**
  - Required response: count stays 2, order is preserved, no word is lost or duplicated over 20 cycles of random out_ready.
- **Mid-stream reset.**
  - Stimulus: assert reset with 3 entries queued.
  - Required response: out_valid=0 and in_ready=1 immediately; err_count=0; the next push is tagged @0.
